// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fetch_sequencer
// Desc   : Program-counter owner and instruction-issue handshake for the 9-bit
//          accumulator CPU (IDLE/FETCH/ISSUE/HALT, all outputs registered).
//          Optional issue watchdog enabled by macro FETCH_WATCHDOG_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned  D         = 12,
    parameter int unsigned  W         = 9,
    parameter logic [W-1:0] HALT_CODE = 9'h1FF,
    parameter int unsigned  WDOG_MAX  = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [W-1:0] rom_data,
    input  logic         exec_done,
    input  logic         branch_en,
    input  logic [D-1:0] branch_target,
    output logic [D-1:0] prog_ctr,
    output logic [W-1:0] instr_out,
    output logic         instr_valid,
    output logic         busy,
    output logic         done,
    output logic         fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [D-1:0] PC_LAST = {D{1'b1}};

    state_t         state_q;
    logic [D-1:0]   pc_q;
    logic [W-1:0]   instr_q;
    logic           valid_q;
    logic           busy_q;
    logic           done_q;

`ifdef FETCH_WATCHDOG_EN
    localparam int unsigned WDOG_W = ($clog2(WDOG_MAX + 1) > 8) ? $clog2(WDOG_MAX + 1) : 8;
    // Fault fires on the edge where the count would reach WDOG_MAX.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

    logic [WDOG_W-1:0] wdog_q;
    logic              fault_q;

    assign fault = fault_q;
`else
    logic [31:0] unused_wdog_max;

    assign unused_wdog_max = WDOG_MAX;
    assign fault           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FETCH_WATCHDOG_EN
            wdog_q  <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (req) begin
                        pc_q    <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
`ifdef FETCH_WATCHDOG_EN
                        fault_q <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    instr_q <= rom_data;
                    if (rom_data == HALT_CODE) begin
                        state_q <= S_HALT;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
`ifdef FETCH_WATCHDOG_EN
                        wdog_q  <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (exec_done) begin
                        valid_q <= 1'b0;
                        if (branch_en) begin
                            pc_q    <= branch_target;
                            state_q <= S_FETCH;
                        end else if (pc_q != PC_LAST) begin
                            pc_q    <= pc_q + 1'b1;
                            state_q <= S_FETCH;
                        end else begin
                            // End of ROM: hold the PC rather than wrapping to 0.
                            state_q <= S_HALT;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
`ifdef FETCH_WATCHDOG_EN
                    else if (wdog_q == WDOG_LAST) begin
                        fault_q <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= S_HALT;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        wdog_q  <= wdog_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign prog_ctr    = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Testbench for fetch_sequencer: cycle table, hand-written corner sequences,
// and randomized programs checked against an address-level program model.
module tb_fetch_sequencer;

    localparam int D    = 12;
    localparam int W    = 9;
    localparam int WDOG = 8;

    logic         clk = 1'b0;
    logic         reset, req, exec_done, branch_en;
    logic [D-1:0] branch_target, prog_ctr;
    logic [W-1:0] rom_data, instr_out;
    logic         instr_valid, busy, done, fault;
    logic [W-1:0] rom [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[prog_ctr];

    fetch_sequencer #(.D(D), .W(W), .HALT_CODE(9'h1FF), .WDOG_MAX(WDOG)) dut (
        .clk(clk), .reset(reset), .req(req), .rom_data(rom_data),
        .exec_done(exec_done), .branch_en(branch_en), .branch_target(branch_target),
        .prog_ctr(prog_ctr), .instr_out(instr_out), .instr_valid(instr_valid),
        .busy(busy), .done(done), .fault(fault)
    );

    typedef struct {
        logic         rst, rq, ed, be;
        logic [11:0]  tgt;
        logic [11:0]  pc;
        logic         v, b, d;
        logic [8:0]   ins;
    } vec_t;

    vec_t tbl [18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [11:0] pc, input logic v,
                           input logic b, input logic d, input logic f, input logic [8:0] ins);
        check({tag, ".pc"}, 32'(prog_ctr), 32'(pc));
        check({tag, ".valid"}, 32'(instr_valid), 32'(v));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".fault"}, 32'(fault), 32'(f));
        check({tag, ".instr"}, 32'(instr_out), 32'(ins));
    endtask

    // Advance until an instruction is issued or the program ends; trigger inputs drop after the first edge.
    task automatic await_event(output int n);
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) begin
                req = 1'b0; exec_done = 1'b0; branch_en = 1'b0;
            end
        end while (!instr_valid && !done && n < 10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int           n;
        int           pc_m;
        bit           running;
        logic [11:0]  tgt;
        bit           take;

        reset = 1'b1; req = 1'b0; exec_done = 1'b0; branch_en = 1'b0; branch_target = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 9'h0AA;
        rom[0] = 9'h012; rom[1] = 9'h034; rom[2] = 9'h077; rom[3] = 9'h1FF;
        rom[5] = 9'h0AB; rom[12'h040] = 9'h0C3; rom[12'hFFF] = 9'h100;
        step(); step();
        reset = 1'b0;
        chk_all("reset", 12'h000, 0, 0, 0, 0, 9'h000);

        //            rst rq ed be tgt      pc      v  b  d  ins
        tbl[0]  = '{0, 1, 0, 0, 12'h000, 12'h000, 0, 1, 0, 9'h000};
        tbl[1]  = '{0, 0, 0, 0, 12'h000, 12'h000, 1, 1, 0, 9'h012};
        tbl[2]  = '{0, 1, 0, 0, 12'h000, 12'h000, 1, 1, 0, 9'h012};
        tbl[3]  = '{0, 0, 1, 0, 12'h000, 12'h001, 0, 1, 0, 9'h012};
        tbl[4]  = '{0, 0, 0, 0, 12'h000, 12'h001, 1, 1, 0, 9'h034};
        tbl[5]  = '{0, 0, 0, 1, 12'h005, 12'h001, 1, 1, 0, 9'h034};
        tbl[6]  = '{0, 0, 1, 1, 12'h005, 12'h005, 0, 1, 0, 9'h034};
        tbl[7]  = '{0, 0, 1, 1, 12'h100, 12'h005, 1, 1, 0, 9'h0AB};
        tbl[8]  = '{0, 0, 1, 1, 12'h040, 12'h040, 0, 1, 0, 9'h0AB};
        tbl[9]  = '{0, 0, 0, 0, 12'h000, 12'h040, 1, 1, 0, 9'h0C3};
        tbl[10] = '{0, 0, 1, 1, 12'h002, 12'h002, 0, 1, 0, 9'h0C3};
        tbl[11] = '{0, 0, 0, 0, 12'h000, 12'h002, 1, 1, 0, 9'h077};
        tbl[12] = '{0, 0, 1, 0, 12'h000, 12'h003, 0, 1, 0, 9'h077};
        tbl[13] = '{0, 0, 0, 0, 12'h000, 12'h003, 0, 0, 1, 9'h1FF};
        tbl[14] = '{0, 0, 1, 1, 12'h040, 12'h003, 0, 0, 1, 9'h1FF};
        tbl[15] = '{0, 1, 0, 0, 12'h000, 12'h000, 0, 1, 0, 9'h1FF};
        tbl[16] = '{0, 0, 0, 0, 12'h000, 12'h000, 1, 1, 0, 9'h012};
        tbl[17] = '{1, 0, 1, 1, 12'h040, 12'h000, 0, 0, 0, 9'h000};

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst; req = tbl[i].rq; exec_done = tbl[i].ed;
            branch_en = tbl[i].be; branch_target = tbl[i].tgt;
            step();
            chk_all($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].v, tbl[i].b, tbl[i].d, 1'b0, tbl[i].ins);
        end
        reset = 1'b0; req = 1'b0; exec_done = 1'b0; branch_en = 1'b0;

        // Branch to the last ROM word, then fall off the end: halt with no wrap, then restart.
        req = 1'b1; step(); req = 1'b0; step();
        exec_done = 1'b1; branch_en = 1'b1; branch_target = 12'hFFF; step();
        exec_done = 1'b0; branch_en = 1'b0; step();
        chk_all("eor_issue", 12'hFFF, 1, 1, 0, 0, 9'h100);
        exec_done = 1'b1; step(); exec_done = 1'b0;
        chk_all("eor_halt", 12'hFFF, 0, 0, 1, 0, 9'h100);
        step();
        chk_all("eor_hold", 12'hFFF, 0, 0, 1, 0, 9'h100);
        req = 1'b1; step(); req = 1'b0;
        chk_all("eor_restart", 12'h000, 0, 1, 0, 0, 9'h100);

        // Execute side never answers.
        reset = 1'b1; step(); reset = 1'b0;
        req = 1'b1; step(); req = 1'b0; step();
        for (int k = 0; k < 7; k++) step();
        chk_all("wdog_pre", 12'h000, 1, 1, 0, 0, 9'h012);
`ifdef FETCH_WATCHDOG_EN
        step();
        chk_all("wdog_fire", 12'h000, 0, 0, 1, 1, 9'h012);
        req = 1'b1; step(); req = 1'b0;
        chk_all("wdog_restart", 12'h000, 0, 1, 0, 0, 9'h012);
`else
        for (int k = 0; k < 93; k++) step();
        chk_all("wdog_none", 12'h000, 1, 1, 0, 0, 9'h012);
`endif

        // Randomized programs against the address-level model.
        for (int p = 0; p < 6; p++) begin
            reset = 1'b1; step(); reset = 1'b0;
            for (int i = 0; i < 4096; i++)
                rom[i] = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
            rom[0] = 9'($urandom_range(0, 510));
            pc_m = 0;
            running = 1'b1;
            req = 1'b1;
            for (int k = 0; k < 40 && running; k++) begin
                await_event(n);
                if (rom[pc_m] == 9'h1FF) begin
                    check("rnd.halt_lat", 32'(n), 32'd2);
                    chk_all("rnd.halt", 12'(pc_m), 0, 0, 1, 0, 9'h1FF);
                    running = 1'b0;
                end else begin
                    check("rnd.issue_lat", 32'(n), 32'd2);
                    chk_all("rnd.issue", 12'(pc_m), 1, 1, 0, 0, rom[pc_m]);
                    for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                        req = 1'($urandom); branch_en = 1'($urandom);
                        branch_target = 12'($urandom);
                        step();
                        check("rnd.stable_instr", 32'(instr_out), 32'(rom[pc_m]));
                        check("rnd.stable_pc", 32'(prog_ctr), 32'(pc_m));
                    end
                    take = ($urandom_range(0, 2) == 0);
                    tgt  = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
                    req = 1'b0; exec_done = 1'b1; branch_en = take; branch_target = tgt;
                    if (take) begin
                        pc_m = int'(tgt);
                    end else if (pc_m == 4095) begin
                        await_event(n);
                        check("rnd.eor_lat", 32'(n), 32'd1);
                        chk_all("rnd.eor", 12'hFFF, 0, 0, 1, 0, rom[4095]);
                        running = 1'b0;
                    end else begin
                        pc_m = pc_m + 1;
                    end
                end
            end
            req = 1'b0; exec_done = 1'b0; branch_en = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
